cdc_handshake_tx: RTL and testbench

Source-domain (sending) end of a four-phase REQ/ACK clock-domain-crossing handshake.
- Captures a data word on a valid pulse and holds it stable on XFER_DATA.
- Raises XFER_REQ toward the destination domain and runs the four-phase sequence against the asynchronous ACK returned by the destination domain.
- ACK is synchronized internally with a NUM_STAGES flop chain.
- Sits beside the destination-side multi-flop synchronizers wherever a multi-bit bus crosses clock domains.

---
 rtl/cdc_handshake_tx_pkg.sv | 14 +
 rtl/cdc_handshake_tx_hs_ack_sync.sv | 26 ++
 rtl/cdc_handshake_tx.sv | 78 +++++++
 tb/tb_cdc_handshake_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cdc_handshake_tx_pkg.sv
// Shared definitions for the four-phase REQ/ACK handshake: FSM encoding and
// default synchronizer depth (also used by the destination-side synchronizer).
package cdc_handshake_tx_pkg;

   localparam int DEF_NUM_STAGES = 2;

   // 2'b11 is unused; the FSM recovers from it to IDLE.
   typedef enum logic [1:0] {
      IDLE        = 2'b00,
      REQ_HI      = 2'b01,
      ACK_WAIT_LO = 2'b10
   } hs_state_t;

endpackage

// File: rtl/cdc_handshake_tx_hs_ack_sync.sv
// 1-bit multi-flop synchronizer for the returning ACK level; latency NUM_STAGES
// edges, no backpressure (free-running level path).
module hs_ack_sync
   import cdc_handshake_tx_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES
) (
   input  logic CLK,
   input  logic RST,
   input  logic ack_async,
   output logic ack_s
);

   logic [NUM_STAGES-1:0] sync_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], ack_async};
      end
   end

   assign ack_s = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source end of a four-phase REQ/ACK crossing: REQ rises 1 cycle after accept,
// DONE pulses after ACK falls; DATA_VALID while BUSY is dropped and flagged.
module cdc_handshake_tx
   import cdc_handshake_tx_pkg::*;
#(
   parameter int NUM_STAGES = DEF_NUM_STAGES,
   parameter int BUS_WIDTH  = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] DATA_IN,
   input  logic                 DATA_VALID,
   input  logic                 ACK_ASYNC,
   output logic [BUS_WIDTH-1:0] XFER_DATA,
   output logic                 XFER_REQ,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 DROPPED
);

   hs_state_t state;
   logic      ack_s;

   hs_ack_sync #(
      .NUM_STAGES (NUM_STAGES)
   ) u_ack_sync (
      .CLK       (CLK),
      .RST       (RST),
      .ack_async (ACK_ASYNC),
      .ack_s     (ack_s)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         XFER_DATA <= '0;
         XFER_REQ  <= 1'b0;
         DONE      <= 1'b0;
         DROPPED   <= 1'b0;
      end else begin
         DONE    <= 1'b0;
         DROPPED <= 1'b0;
         case (state)
            IDLE: begin
               if (DATA_VALID) begin
                  XFER_DATA <= DATA_IN;
                  XFER_REQ  <= 1'b1;
                  state     <= REQ_HI;
               end
            end
            REQ_HI: begin
               DROPPED <= DATA_VALID;
               if (ack_s) begin
                  XFER_REQ <= 1'b0;
                  state    <= ACK_WAIT_LO;
               end
            end
            ACK_WAIT_LO: begin
               DROPPED <= DATA_VALID;
               // Data stays held until ACK is seen low, so the far side may
               // still be reading it while REQ is already down.
               if (!ack_s) begin
                  DONE  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               DROPPED  <= DATA_VALID;
               XFER_REQ <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx at NUM_STAGES = 2 (table + corner sequences)
// and NUM_STAGES = 3 (basic transfer timing).
module tb_cdc_handshake_tx;

   logic       CLK;
   logic       RST;
   logic [7:0] din2, din3;
   logic       dv2, dv3, ack2, ack3;
   logic [7:0] xd2, xd3;
   logic       req2, req3, busy2, busy3, done2, done3, drop2, drop3;

   int compared   = 0;
   int mismatched = 0;

   logic       p_req2 = 1'b0, p_req3 = 1'b0;
   logic [7:0] p_xd2 = '0, p_xd3 = '0;

   cdc_handshake_tx #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
      .CLK(CLK), .RST(RST), .DATA_IN(din2), .DATA_VALID(dv2), .ACK_ASYNC(ack2),
      .XFER_DATA(xd2), .XFER_REQ(req2), .BUSY(busy2), .DONE(done2), .DROPPED(drop2)
   );

   cdc_handshake_tx #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
      .CLK(CLK), .RST(RST), .DATA_IN(din3), .DATA_VALID(dv3), .ACK_ASYNC(ack3),
      .XFER_DATA(xd3), .XFER_REQ(req3), .BUSY(busy3), .DONE(done3), .DROPPED(drop3)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic       dv;
      logic [7:0] din;
      logic       ack;
      logic       req;
      logic [7:0] data;
      logic       busy;
      logic       done;
      logic       drop;
   } vec_t;

   vec_t tv [27];

   function automatic vec_t mk(logic dv, logic [7:0] din, logic ack, logic req,
                               logic [7:0] data, logic busy, logic done, logic drop);
      vec_t v;
      v.dv = dv; v.din = din; v.ack = ack; v.req = req;
      v.data = data; v.busy = busy; v.done = done; v.drop = drop;
      return v;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge. XFER_DATA must not
   // move while XFER_REQ stays high across consecutive samples.
   task automatic tick();
      @(posedge CLK);
      #1;
      if (p_req2 && req2) check("stable2.xfer_data", int'(xd2), int'(p_xd2));
      if (p_req3 && req3) check("stable3.xfer_data", int'(xd3), int'(p_xd3));
      p_req2 = req2; p_xd2 = xd2;
      p_req3 = req3; p_xd3 = xd3;
   endtask

   initial begin
      int n;

      //      dv   din    ack   req   data   busy  done  drop
      tv[0]  = mk(1, 8'hA5, 0,   1, 8'hA5, 1, 0, 0);
      tv[1]  = mk(0, 8'h00, 0,   1, 8'hA5, 1, 0, 0);
      tv[2]  = mk(1, 8'h3C, 0,   1, 8'hA5, 1, 0, 1);
      tv[3]  = mk(0, 8'h00, 1,   1, 8'hA5, 1, 0, 0);
      tv[4]  = mk(0, 8'h00, 1,   1, 8'hA5, 1, 0, 0);
      tv[5]  = mk(0, 8'h00, 1,   0, 8'hA5, 1, 0, 0);
      tv[6]  = mk(0, 8'h00, 1,   0, 8'hA5, 1, 0, 0);
      tv[7]  = mk(0, 8'h00, 0,   0, 8'hA5, 1, 0, 0);
      tv[8]  = mk(0, 8'h00, 0,   0, 8'hA5, 1, 0, 0);
      tv[9]  = mk(0, 8'h00, 0,   0, 8'hA5, 0, 1, 0);
      tv[10] = mk(1, 8'h11, 0,   1, 8'h11, 1, 0, 0);
      tv[11] = mk(0, 8'h00, 1,   1, 8'h11, 1, 0, 0);
      tv[12] = mk(0, 8'h00, 1,   1, 8'h11, 1, 0, 0);
      tv[13] = mk(0, 8'h00, 1,   0, 8'h11, 1, 0, 0);
      tv[14] = mk(1, 8'h3C, 0,   0, 8'h11, 1, 0, 1);
      tv[15] = mk(0, 8'h00, 0,   0, 8'h11, 1, 0, 0);
      tv[16] = mk(0, 8'h00, 0,   0, 8'h11, 0, 1, 0);
      tv[17] = mk(0, 8'h00, 0,   0, 8'h11, 0, 0, 0);
      tv[18] = mk(1, 8'h77, 1,   1, 8'h77, 1, 0, 0);
      tv[19] = mk(0, 8'h00, 1,   1, 8'h77, 1, 0, 0);
      tv[20] = mk(0, 8'h00, 1,   0, 8'h77, 1, 0, 0);
      tv[21] = mk(0, 8'h00, 1,   0, 8'h77, 1, 0, 0);
      tv[22] = mk(0, 8'h00, 1,   0, 8'h77, 1, 0, 0);
      tv[23] = mk(0, 8'h00, 0,   0, 8'h77, 1, 0, 0);
      tv[24] = mk(0, 8'h00, 0,   0, 8'h77, 1, 0, 0);
      tv[25] = mk(0, 8'h00, 0,   0, 8'h77, 0, 1, 0);
      tv[26] = mk(0, 8'h00, 0,   0, 8'h77, 0, 0, 0);

      RST = 1'b0;
      din2 = '0; dv2 = 1'b0; ack2 = 1'b0;
      din3 = '0; dv3 = 1'b0; ack3 = 1'b0;
      tick();
      tick();
      check("reset.req2",  int'(req2),  0);
      check("reset.data2", int'(xd2),   0);
      check("reset.busy2", int'(busy2), 0);
      check("reset.done2", int'(done2), 0);
      check("reset.drop2", int'(drop2), 0);
      check("reset.req3",  int'(req3),  0);
      check("reset.busy3", int'(busy3), 0);
      RST = 1'b1;
      tick();

      // Basic, drop-while-busy, back-to-back and early-ACK transfers.
      for (int i = 0; i < 27; i++) begin
         dv2 = tv[i].dv; din2 = tv[i].din; ack2 = tv[i].ack;
         tick();
         check($sformatf("vec%0d.req", i),     int'(req2),  int'(tv[i].req));
         check($sformatf("vec%0d.data", i),    int'(xd2),   int'(tv[i].data));
         check($sformatf("vec%0d.busy", i),    int'(busy2), int'(tv[i].busy));
         check($sformatf("vec%0d.done", i),    int'(done2), int'(tv[i].done));
         check($sformatf("vec%0d.dropped", i), int'(drop2), int'(tv[i].drop));
      end

      // Reset asserted mid-transfer must clear outputs without a clock edge.
      dv2 = 1'b1; din2 = 8'hC3;
      tick();
      dv2 = 1'b0;
      tick();
      check("rst.pre_req", int'(req2), 1);
      #2;
      RST = 1'b0;
      #1;
      check("rst.async_req",  int'(req2),  0);
      check("rst.async_data", int'(xd2),   0);
      check("rst.async_busy", int'(busy2), 0);
      tick();
      RST = 1'b1;
      tick();
      check("rst.idle_req", int'(req2), 0);

      dv2 = 1'b1; din2 = 8'h5A;
      tick();
      dv2 = 1'b0;
      check("post_rst.req",  int'(req2), 1);
      check("post_rst.data", int'(xd2),  8'h5A);
      ack2 = 1'b1;
      n = 0;
      while (req2 && n < 20) begin tick(); n++; end
      check("post_rst.req_fall_cycles", n, 3);
      ack2 = 1'b0;
      n = 0;
      while (!done2 && n < 20) begin tick(); n++; end
      check("post_rst.done_cycles", n, 3);
      check("post_rst.data_held", int'(xd2), 8'h5A);
      tick();
      check("post_rst.done_single", int'(done2), 0);

      // Deeper synchronizer: each ACK edge takes one more cycle to act on.
      dv3 = 1'b1; din3 = 8'hD2;
      tick();
      dv3 = 1'b0;
      check("n3.req",  int'(req3),  1);
      check("n3.data", int'(xd3),   8'hD2);
      check("n3.busy", int'(busy3), 1);
      ack3 = 1'b1;
      n = 0;
      while (req3 && n < 20) begin tick(); n++; end
      check("n3.req_fall_cycles", n, 4);
      ack3 = 1'b0;
      n = 0;
      while (!done3 && n < 20) begin tick(); n++; end
      check("n3.done_cycles", n, 4);
      check("n3.busy_at_done", int'(busy3), 0);
      tick();
      check("n3.done_single", int'(done3), 0);
      check("n3.data_held",   int'(xd3),   8'hD2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
